// File: rtl/mul_seq_ctrl.sv
// Issue/return sequencer for the 16x16 signed sequential Booth multiplier core.
// Accepts one operation at a time, drives the core, and returns tagged results through a small FIFO.
`timescale 1ns/1ps
module mul_seq_ctrl #(
    parameter int TAG_W       = 4,
    parameter int FIFO_DEPTH  = 2,
    parameter int TIMEOUT_CYC = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_x,
    input  logic [15:0]      in_y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_start,
    output logic [15:0]      mul_x,
    output logic [15:0]      mul_y,
    input  logic             mul_busy,
    input  logic [31:0]      mul_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LAUNCH  = 3'd1;
    localparam logic [2:0] WAIT_HI = 3'd2;
    localparam logic [2:0] RUN     = 3'd3;
    localparam logic [2:0] CAPTURE = 3'd4;

    localparam int WAIT_HI_CYC = 2;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC + 1) : 2;

    localparam logic [15:0] MIN_NEG = 16'h8000;

    logic [2:0]       state_q, state_d;
    logic [15:0]      mul_x_q, mul_x_d;
    logic [15:0]      mul_y_q, mul_y_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic             push_v;
    logic [31:0]      push_z;
    logic [TAG_W-1:0] push_tag;
    logic             push_err;
    logic             pop;
    logic             hs;

    logic [31:0]      z_mem   [FIFO_DEPTH];
    logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];
    logic             err_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    // Only one op is in flight, so a free slot at accept time guarantees room for its result.
    assign in_ready  = rst_n && (state_q == IDLE) && (cnt_q < CNT_W'(FIFO_DEPTH)) && !mul_busy;
    assign hs        = in_valid && in_ready;
    assign mul_start = (state_q == LAUNCH);
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;

    always_comb begin
        state_d  = state_q;
        mul_x_d  = mul_x_q;
        mul_y_d  = mul_y_q;
        tag_d    = tag_q;
        tmo_d    = tmo_q;
        push_v   = 1'b0;
        push_z   = 32'h0;
        push_tag = tag_q;
        push_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    tag_d    = in_tag;
                    push_tag = in_tag;
                    if (in_x == 16'h0 || in_y == 16'h0) begin
                        push_v = 1'b1;
                    end else if (in_x == MIN_NEG && in_y == MIN_NEG) begin
                        push_v = 1'b1;
                        push_z = 32'h4000_0000;
                    end else if (in_x == MIN_NEG) begin
                        // The core cannot negate -32768 on its multiplicand port; its multiplier port can.
                        mul_x_d = in_y;
                        mul_y_d = in_x;
                        state_d = LAUNCH;
                    end else begin
                        mul_x_d = in_x;
                        mul_y_d = in_y;
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                tmo_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (mul_busy) begin
                    tmo_d   = '0;
                    state_d = RUN;
                end else if (tmo_q == TMO_W'(WAIT_HI_CYC - 1)) begin
                    push_v   = 1'b1;
                    push_err = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RUN: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (!mul_busy) begin
                    state_d = CAPTURE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    push_v   = 1'b1;
                    push_err = 1'b1;
                    state_d  = IDLE;
                end
            end
            CAPTURE: begin
                push_v  = 1'b1;
                push_z  = mul_z;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mul_x_q <= 16'h0;
            mul_y_q <= 16'h0;
            tag_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            mul_x_q <= mul_x_d;
            mul_y_q <= mul_y_d;
            tag_q   <= tag_d;
            tmo_q   <= tmo_d;
        end
    end

    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_z     = z_mem[rd_ptr_q];
    assign out_tag   = tag_mem[rd_ptr_q];
    assign out_err   = err_mem[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_v) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(push_v) - CNT_W'(pop);
        end
    end

    // Storage is not reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (push_v) begin
            z_mem[wr_ptr_q]   <= push_z;
            tag_mem[wr_ptr_q] <= push_tag;
            err_mem[wr_ptr_q] <= push_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push_v && !pop && cnt_q == CNT_W'(FIFO_DEPTH)))
                else $error("result fifo overflow");
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: directed requests, behavioural core model, queue-based result scoreboard.
`timescale 1ns/1ps
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0, in_y = '0;
    logic [3:0]  in_tag = '0;
    logic        mul_start;
    logic [15:0] mul_x, mul_y;
    logic        mul_busy;
    logic [31:0] mul_z;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_z;
    logic [3:0]  out_tag;
    logic        out_err;

    mul_seq_ctrl #(.TAG_W(4), .FIFO_DEPTH(2), .TIMEOUT_CYC(24)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y), .mul_busy(mul_busy), .mul_z(mul_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_tag(out_tag), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] z;
        logic [3:0]  tag;
        logic        err;
        int          lat;
        int          hs;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int checks = 0, errors = 0;
    int cyc = 0, nstarts = 0;
    int pop_last = 0, pop_prev = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Core model: busy rises the edge after start and stays high busy_len cycles.
    logic        busy_m = 1'b0;
    logic [31:0] z_m = '0;
    int          bcnt = 0;
    int          busy_len = 17;
    bit          no_busy = 1'b0;
    assign mul_busy = busy_m;
    assign mul_z    = z_m;

    always @(posedge clk) begin
        cyc++;
        if (mul_start && !no_busy) begin
            busy_m <= 1'b1;
            bcnt   <= busy_len;
            z_m    <= $signed(mul_x) * $signed(mul_y);
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) busy_m <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (mul_start) nstarts++;
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", {28'h0, out_tag, out_z}, 64'h0);
            end else begin
                me = sbq.pop_front();
                chk("res_z", out_z, me.z);
                chk("res_tag", out_tag, me.tag);
                chk("res_err", out_err, me.err);
                if (me.lat >= 0) chk("res_latency", cyc - me.hs, me.lat);
            end
            pop_prev = pop_last;
            pop_last = cyc;
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [3:0] tag,
                        input logic [31:0] z, input logic err, input int lat, input bit track);
        int   n;
        exp_t e;
        in_x = x; in_y = y; in_tag = tag; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        chk("accept", in_ready, 1'b1);
        if (track) begin
            e.z = z; e.tag = tag; e.err = err; e.lat = lat; e.hs = cyc;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sbq.size() != 0 || out_valid) && n < 200);
        chk("drain", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_core_idle();
        int n;
        n = 0;
        while (busy_m && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("core_idle", busy_m, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s0;
        // reset state
        #12;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_mul_start", mul_start, 1'b0);
        chk("rst_mul_xy", {mul_x, mul_y}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // nominal: 3 * -5
        s0 = nstarts;
        send(16'd3, 16'hFFFB, 4'd2, 32'hFFFF_FFF1, 1'b0, 21, 1'b1);
        chk("launch_start", mul_start, 1'b1);
        drain();
        chk("starts_nominal", nstarts - s0, 1);

        // -32768 multiplicand is swapped onto the multiplier port
        s0 = nstarts;
        send(16'h8000, 16'd7, 4'd3, 32'hFFFC_8000, 1'b0, 21, 1'b1);
        chk("swap_mul_x", mul_x, 16'd7);
        chk("swap_mul_y", mul_y, 16'h8000);
        drain();
        chk("starts_swap", nstarts - s0, 1);
        s0 = nstarts;
        send(16'h8000, 16'h8000, 4'd4, 32'h4000_0000, 1'b0, 1, 1'b1);
        drain();
        chk("starts_minmin", nstarts - s0, 0);

        // zero shortcuts back to back
        s0 = nstarts;
        send(16'd0, 16'd1234, 4'd5, 32'h0, 1'b0, 1, 1'b1);
        send(16'd55, 16'd0, 4'd6, 32'h0, 1'b0, 1, 1'b1);
        drain();
        chk("zero_consecutive", pop_last - pop_prev, 1);
        chk("starts_zero", nstarts - s0, 0);

        // back-pressure: two results queue, third waits for a pop
        out_ready = 1'b0;
        send(16'd100, 16'd200, 4'd7, 32'h0000_4E20, 1'b0, -1, 1'b1);
        send(16'hFFFE, 16'd300, 4'd8, 32'hFFFF_FDA8, 1'b0, -1, 1'b1);
        repeat (30) @(negedge clk);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_out_valid", out_valid, 1'b1);
        chk("hold_z0", out_z, 32'h0000_4E20);
        @(negedge clk);
        chk("hold_z1", out_z, 32'h0000_4E20);
        chk("hold_tag", out_tag, 4'd7);
        @(posedge clk); #1;
        in_x = 16'd1000; in_y = 16'hFC18; in_tag = 4'd9; in_valid = 1'b1;
        out_ready = 1'b1;
        sbq.push_back('{z: 32'hFFF0_BDC0, tag: 4'd9, err: 1'b0, lat: -1, hs: 0});
        @(negedge clk);
        chk("third_wait", in_ready, 1'b0);
        @(negedge clk);
        chk("third_accept", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // busy stuck high -> timeout after 24 RUN cycles
        busy_len = 30;
        send(16'd9, 16'd9, 4'd10, 32'h0, 1'b1, 27, 1'b1);
        drain();
        wait_core_idle();
        busy_len = 17;

        // busy never rises -> abort after 2 WAIT_HI cycles
        no_busy = 1'b1;
        send(16'd9, 16'd9, 4'd11, 32'h0, 1'b1, 4, 1'b1);
        drain();
        no_busy = 1'b0;

        // reset during RUN with a result pending
        out_ready = 1'b0;
        send(16'd0, 16'd9, 4'd13, 32'h0, 1'b0, -1, 1'b0);
        send(16'd5, 16'd6, 4'd12, 32'h0, 1'b0, -1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_out_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_mul_start", mul_start, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_busy_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        wait_core_idle();
        @(negedge clk);
        chk("postrst_idle_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("final_out_valid", out_valid, 1'b0);
        chk("final_sb_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
